// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
// Measures the high time of a hobby-servo PWM pulse train in microseconds,
// range-checks each pulse and flags loss of signal.
// Optional build macro: PWM_DEC_FILTER_EN adds a 4-clock glitch filter
// after the input synchronizer. Edges are delayed by 3 clocks, equally on
// rise and fall, so measured widths are unaffected.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SYNC      | after reset or stuck-high timeout; wait for a low line
// WAIT_RISE | line low, waiting for the first rising edge of a frame
// HIGH      | pulse in progress, timebase counting the high time
// LOW       | pulse measured, waiting for the next frame's rising edge
module servo_pwm_decoder #(
  parameter int CLK_PER_US = 50,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int TIMEOUT_US = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [11:0] width_us,
  output logic        valid,
  output logic        range_err,
  output logic        lost
);

  localparam int              PW        = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0]   PRE_MAX   = PW'(CLK_PER_US - 1);
  localparam logic [16:0]     MIN_W     = 17'(MIN_US);
  localparam logic [16:0]     MAX_W     = 17'(MAX_US);
  localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT_US);
`ifdef PWM_DEC_FILTER_EN
  localparam logic [2:0]      SETTLE    = 3'd6;
`else
  localparam logic [2:0]      SETTLE    = 3'd3;
`endif

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          sync_q1, sync_q2;
  logic          rise, fall, lvl_now;
  logic [2:0]    settle_cnt;
  logic          armed;
  logic [PW-1:0] presc;
  logic [15:0]   us_cnt;
  logic [16:0]   width_meas;
  logic          in_range;
  logic          timeout;
  logic [11:0]   width_nxt;
  logic          valid_nxt, range_nxt, lost_nxt;

  // Two-flop synchronizer for the asynchronous servo input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PWM_DEC_FILTER_EN
  logic [2:0] hist;
  logic       filt_lvl;
  logic       chg;

  // A new level is accepted once it has been seen on 4 consecutive clocks
  assign chg     = (sync_q2 != filt_lvl) && (hist == {3{sync_q2}});
  assign rise    = chg & sync_q2;
  assign fall    = chg & ~sync_q2;
  assign lvl_now = chg ? sync_q2 : filt_lvl;

  // Sample history and filtered level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= 3'b000;
      filt_lvl <= 1'b0;
    end else begin
      hist <= {hist[1:0], sync_q2};
      if (chg) filt_lvl <= sync_q2;
    end
  end
`else
  logic sync_prev;

  assign rise    = sync_q2 & ~sync_prev;
  assign fall    = ~sync_q2 & sync_prev;
  assign lvl_now = sync_q2;

  // Previous synchronized level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_prev <= 1'b0;
    else     sync_prev <= sync_q2;
  end
`endif

  // The input pipeline reads 0 straight out of reset regardless of pwm_in,
  // so SYNC must not trust the level until the pipeline has refilled;
  // otherwise a pulse already in progress would look like a fresh rise.
  assign armed = (settle_cnt == SETTLE);

  // Post-reset settle counter, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         settle_cnt <= 3'd0;
    else if (!armed) settle_cnt <= settle_cnt + 3'd1;
  end

  // Microsecond timebase, restarted by every detected rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      us_cnt <= 16'd0;
    end else if (rise) begin
      presc  <= '0;
      us_cnt <= 16'd0;
    end else if (presc == PRE_MAX) begin
      presc <= '0;
      if (us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // On the fall cycle the counters hold high_cycles-1 clocks; the current
  // cycle completes another microsecond exactly when the prescaler sits at
  // its last count, which gives an exact floor(high_cycles / CLK_PER_US).
  assign width_meas = {1'b0, us_cnt} + ((presc == PRE_MAX) ? 17'd1 : 17'd0);
  assign in_range   = (width_meas >= MIN_W) && (width_meas <= MAX_W);
  assign timeout    = (us_cnt == TIMEOUT_C);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  // Next state and next output values; a rise always beats a timeout
  always_comb begin
    state_nxt = state;
    width_nxt = width_us;
    valid_nxt = 1'b0;
    range_nxt = range_err;
    lost_nxt  = lost;
    case (state)
      SYNC: begin
        if (armed && !lvl_now) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
          if (in_range) begin
            width_nxt = width_meas[11:0];
            valid_nxt = 1'b1;
            range_nxt = 1'b0;
            lost_nxt  = 1'b0;
          end else begin
            range_nxt = 1'b1;
          end
        end else if (timeout) begin
          lost_nxt  = 1'b1;
          state_nxt = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
        end else if (timeout) begin
          lost_nxt  = 1'b1;
          state_nxt = WAIT_RISE;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_us  <= 12'd0;
      valid     <= 1'b0;
      range_err <= 1'b0;
      lost      <= 1'b1;
    end else begin
      width_us  <= width_nxt;
      valid     <= valid_nxt;
      range_err <= range_nxt;
      lost      <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder with scaled-down parameters:
// 3 clocks per us, range 50..250 us, timeout 600 us.
module tb_servo_pwm_decoder;

  localparam int CPU = 3;
  localparam int TMO = 600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [11:0] width_us;
  logic        valid;
  logic        range_err;
  logic        lost;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_pushed = 0;
  int exp_q[$];

  servo_pwm_decoder #(
    .CLK_PER_US(CPU),
    .MIN_US(50),
    .MAX_US(250),
    .TIMEOUT_US(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .width_us(width_us),
    .valid(valid),
    .range_err(range_err),
    .lost(lost)
  );

  always #5 clk = ~clk;

  // Scoreboard: every valid strobe must match the oldest expected width
  always @(negedge clk) begin
    if (!rst && valid) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid width_us=%0d (no pulse expected)", width_us);
      end else begin
        automatic int exp_w = exp_q.pop_front();
        if (width_us !== 12'(exp_w) || range_err !== 1'b0 || lost !== 1'b0) begin
          errors++;
          $display("FAIL valid_width got width=%0d range_err=%0b lost=%0b expected width=%0d range_err=0 lost=0",
                   width_us, range_err, lost, exp_w);
        end
      end
    end
  end

  task automatic drive_pulse(input int hi, input int lo);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic expect_pulse(input int w_us, input int hi, input int lo);
    exp_q.push_back(w_us);
    n_pushed++;
    drive_pulse(hi, lo);
  endtask

  task automatic test_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || n_valid != n_pushed) begin
      errors++;
      $display("FAIL %s_drained got valids=%0d pending=%0d expected valids=%0d pending=0",
               name, n_valid, exp_q.size(), n_pushed);
      exp_q.delete();
      n_valid = n_pushed;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (width_us !== 12'd0 || valid !== 1'b0 || range_err !== 1'b0 || lost !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got w=%0d v=%0b re=%0b lost=%0b expected 0 0 0 1",
               width_us, valid, range_err, lost);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (width_us !== 12'd0 || range_err !== 1'b0 || lost !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle got w=%0d re=%0b lost=%0b expected 0 0 1", width_us, range_err, lost);
    end
  endtask

  task automatic test_nominal();
    int v0;
    v0 = n_valid;
    exp_q.push_back(150);
    n_pushed++;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (150 * CPU) @(negedge clk);
    pwm_in = 1'b0;
    checks++;
    if (lost !== 1'b1) begin
      errors++;
      $display("FAIL lost_before_first got %0b expected 1", lost);
    end
    repeat (300 * CPU) @(negedge clk);
    checks++;
    if (lost !== 1'b0 || range_err !== 1'b0 || width_us !== 12'd150) begin
      errors++;
      $display("FAIL nominal_first got lost=%0b re=%0b w=%0d expected 0 0 150", lost, range_err, width_us);
    end
    for (int i = 0; i < 4; i++) expect_pulse(150, 150 * CPU, 300 * CPU);
    checks++;
    if (n_valid - v0 != 5) begin
      errors++;
      $display("FAIL nominal_count got %0d expected 5", n_valid - v0);
    end
    test_drained("nominal");
  endtask

  task automatic test_exact_floor();
    expect_pulse(150, 150 * CPU + 2, 300 * CPU);
    expect_pulse(149, 150 * CPU - 1, 300 * CPU);
    expect_pulse(150, 150 * CPU, 300 * CPU);
    checks++;
    if (width_us !== 12'd150) begin
      errors++;
      $display("FAIL floor_last got %0d expected 150", width_us);
    end
    test_drained("floor");
  endtask

  task automatic test_bounds();
    expect_pulse(50, 50 * CPU, 300 * CPU);
    expect_pulse(250, 250 * CPU, 300 * CPU);
    drive_pulse(251 * CPU, 300 * CPU);
    checks++;
    if (range_err !== 1'b1 || width_us !== 12'd250) begin
      errors++;
      $display("FAIL bound_251 got re=%0b w=%0d expected 1 250", range_err, width_us);
    end
    test_drained("bounds");
  endtask

  task automatic test_recover();
    expect_pulse(150, 150 * CPU, 300 * CPU);
    drive_pulse(40 * CPU, 300 * CPU);
    checks++;
    if (range_err !== 1'b1 || width_us !== 12'd150) begin
      errors++;
      $display("FAIL short_pulse got re=%0b w=%0d expected 1 150", range_err, width_us);
    end
    expect_pulse(100, 100 * CPU, 300 * CPU);
    checks++;
    if (range_err !== 1'b0 || width_us !== 12'd100) begin
      errors++;
      $display("FAIL recover got re=%0b w=%0d expected 0 100", range_err, width_us);
    end
    test_drained("recover");
  endtask

  task automatic test_timeout_low();
    exp_q.push_back(150);
    n_pushed++;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (150 * CPU) @(negedge clk);
    pwm_in = 1'b0;
    repeat (TMO * CPU - 150 * CPU) @(negedge clk);
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got lost=%0b expected 0", lost);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (lost !== 1'b1 || width_us !== 12'd150 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_low got lost=%0b w=%0d re=%0b expected 1 150 0", lost, width_us, range_err);
    end
    test_drained("timeout_low");
  endtask

  task automatic test_stuck_high();
    expect_pulse(150, 150 * CPU, 300 * CPU);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (TMO * CPU - 6) @(negedge clk);
    checks++;
    if (lost !== 1'b0) begin
      errors++;
      $display("FAIL stuck_early got lost=%0b expected 0", lost);
    end
    repeat (18) @(negedge clk);
    checks++;
    if (lost !== 1'b1 || width_us !== 12'd150) begin
      errors++;
      $display("FAIL stuck_high got lost=%0b w=%0d expected 1 150", lost, width_us);
    end
    repeat (600) @(negedge clk);
    pwm_in = 1'b0;
    repeat (300 * CPU) @(negedge clk);
    checks++;
    if (lost !== 1'b1 || width_us !== 12'd150) begin
      errors++;
      $display("FAIL stuck_release got lost=%0b w=%0d expected 1 150", lost, width_us);
    end
    expect_pulse(120, 120 * CPU, 300 * CPU);
    checks++;
    if (lost !== 1'b0 || width_us !== 12'd120) begin
      errors++;
      $display("FAIL stuck_fresh got lost=%0b w=%0d expected 0 120", lost, width_us);
    end
    test_drained("stuck");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (70 * CPU) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (width_us !== 12'd0 || valid !== 1'b0 || range_err !== 1'b0 || lost !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got w=%0d v=%0b re=%0b lost=%0b expected 0 0 0 1",
               width_us, valid, range_err, lost);
    end
    rst = 1'b0;
    repeat (100 * CPU) @(negedge clk);
    pwm_in = 1'b0;
    repeat (300 * CPU) @(negedge clk);
    checks++;
    if (width_us !== 12'd0 || range_err !== 1'b0 || lost !== 1'b1) begin
      errors++;
      $display("FAIL reset_partial got w=%0d re=%0b lost=%0b expected 0 0 1", width_us, range_err, lost);
    end
    expect_pulse(150, 150 * CPU, 300 * CPU);
    checks++;
    if (width_us !== 12'd150 || lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_next got w=%0d lost=%0b expected 150 0", width_us, lost);
    end
    test_drained("reset_mid");
  endtask

  task automatic test_glitch();
    expect_pulse(100, 100 * CPU, 100 * CPU);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
`ifdef PWM_DEC_FILTER_EN
    if (width_us !== 12'd100 || range_err !== 1'b0 || lost !== 1'b0) begin
      errors++;
      $display("FAIL glitch_filtered got w=%0d re=%0b lost=%0b expected 100 0 0", width_us, range_err, lost);
    end
`else
    if (width_us !== 12'd100 || range_err !== 1'b1 || lost !== 1'b0) begin
      errors++;
      $display("FAIL glitch_raw got w=%0d re=%0b lost=%0b expected 100 1 0", width_us, range_err, lost);
    end
`endif
    expect_pulse(200, 200 * CPU, 300 * CPU);
    checks++;
    if (width_us !== 12'd200 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_after got w=%0d re=%0b expected 200 0", width_us, range_err);
    end
    test_drained("glitch");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_exact_floor();
    test_bounds();
    test_recover();
    test_timeout_low();
    test_stuck_high();
    test_reset_mid();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
